// File: rtl/buscador_datapath.sv
// Pattern-search datapath: text/pattern buffers, ti/pi indices, comparator and match counter.
// Optional BUSCADOR_POS_EN implements the match_pos register; otherwise match_pos is tied to 0.
module buscador_datapath #(
  parameter int DATA_W     = 8,
  parameter int TEXT_DEPTH = 64,
  parameter int PAT_DEPTH  = 16,
  localparam int IW = $clog2(TEXT_DEPTH + 1),
  localparam int PW = $clog2(PAT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [IW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IW-1:0]     text_len,
  input  logic [PW-1:0]     pat_len,
  input  logic              set_Iniciales,
  input  logic              patron_si,
  input  logic              patron_fin,
  input  logic              patron_cero,
  input  logic              patron_texto_suma,
  input  logic              text_suma,
  input  logic              sumatexto,
  output logic              fin,
  output logic              igual,
  output logic              pFin,
  output logic              busy,
  output logic [IW-1:0]     match_count,
  output logic [IW-1:0]     match_pos
);

  localparam int TA = (TEXT_DEPTH > 1) ? $clog2(TEXT_DEPTH) : 1;
  localparam int PA = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;

  logic [DATA_W-1:0] text_mem [TEXT_DEPTH];
  logic [DATA_W-1:0] pat_mem  [PAT_DEPTH];

  logic [IW-1:0] ti, tl_r;
  logic [PW-1:0] pi, pl_r;

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      if (!wr_sel) begin
        if (wr_addr < IW'(TEXT_DEPTH)) text_mem[wr_addr[TA-1:0]] <= wr_data;
      end else begin
        if (wr_addr < IW'(PAT_DEPTH)) pat_mem[wr_addr[PA-1:0]] <= wr_data;
      end
    end
  end

  logic ti_ok, pi_ok;
  assign fin   = (ti >= tl_r) || (pl_r == '0);
  assign ti_ok = ti < IW'(TEXT_DEPTH);
  assign pi_ok = pi < PW'(PAT_DEPTH);
  assign igual = !fin && ti_ok && pi_ok &&
                 (text_mem[ti[TA-1:0]] == pat_mem[pi[PA-1:0]]);
  assign pFin  = (pl_r != '0) && (pi == pl_r - PW'(1));

  // ti saturates at tl_r: any advancing strobe while fin is a no-op on ti.
  logic [IW-1:0] ti_adv, cnt_inc, pos_now;
  logic          hit;
  assign ti_adv  = fin ? ti : ti + IW'(1);
  assign cnt_inc = (&match_count) ? match_count : match_count + IW'(1);
  assign pos_now = ti - IW'(pl_r) + IW'(1);
  assign hit     = !set_Iniciales &&
                   (patron_fin || (!patron_si && patron_texto_suma && pl_r == PW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ti          <= '0;
      pi          <= '0;
      tl_r        <= '0;
      pl_r        <= '0;
      match_count <= '0;
      busy        <= 1'b0;
    end else begin
      if (busy && fin) busy <= 1'b0;
      if (hit) match_count <= cnt_inc;
      if (set_Iniciales) begin
        ti          <= '0;
        pi          <= '0;
        match_count <= '0;
        tl_r        <= (text_len > IW'(TEXT_DEPTH)) ? IW'(TEXT_DEPTH) : text_len;
        pl_r        <= (pat_len > PW'(PAT_DEPTH)) ? PW'(PAT_DEPTH) : pat_len;
        busy        <= 1'b1;
      end else if (patron_fin) begin
        ti <= ti_adv;
        pi <= '0;
      end else if (patron_si) begin
        ti <= ti_adv;
        pi <= pi + PW'(1);
      end else if (patron_texto_suma) begin
        ti <= ti_adv;
        pi <= (pl_r == PW'(1)) ? PW'(0) : PW'(1);
      end else if (text_suma) begin
        ti <= ti_adv;
      end else if (patron_cero) begin
        pi <= '0;
      end else if (sumatexto) begin
        ti <= ti_adv;
        pi <= '0;
      end
    end
  end

`ifdef BUSCADOR_POS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                match_pos <= '0;
    else if (set_Iniciales) match_pos <= '0;
    else if (hit)           match_pos <= pos_now;
  end
`else
  assign match_pos = '0;
  logic unused_pos;
  assign unused_pos = ^pos_now;
`endif

endmodule

// File: tb/tb_buscador_datapath.sv
// Directed self-checking bench for buscador_datapath; a tiny naive-search FSM drives the strobes.
module tb_buscador_datapath;
  localparam int IW = 7;
  localparam int PW = 5;
`ifdef BUSCADOR_POS_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  localparam logic [6:0] S_SET  = 7'b0000001;
  localparam logic [6:0] S_PFIN = 7'b0000010;
  localparam logic [6:0] S_PSI  = 7'b0000100;
  localparam logic [6:0] S_PTS  = 7'b0001000;
  localparam logic [6:0] S_TSUM = 7'b0010000;
  localparam logic [6:0] S_PCER = 7'b0100000;

  logic          clk = 0, rst = 1;
  logic          wr_en = 0, wr_sel = 0;
  logic [IW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [IW-1:0] text_len = '0;
  logic [PW-1:0] pat_len = '0;
  logic [6:0]    strb = '0;
  logic          fin, igual, pFin, busy;
  logic [IW-1:0] match_count, match_pos;

  int tests = 0, fails = 0;

  buscador_datapath dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .text_len(text_len), .pat_len(pat_len),
    .set_Iniciales(strb[0]), .patron_fin(strb[1]), .patron_si(strb[2]),
    .patron_texto_suma(strb[3]), .text_suma(strb[4]), .patron_cero(strb[5]), .sumatexto(strb[6]),
    .fin(fin), .igual(igual), .pFin(pFin), .busy(busy),
    .match_count(match_count), .match_pos(match_pos)
  );

  always #5 clk = ~clk;

  task automatic pulse(input logic [6:0] s);
    strb = s;
    @(posedge clk); #1;
    strb = '0;
  endtask

  task automatic wr(input logic sel, input int addr, input logic [7:0] d);
    wr_en = 1; wr_sel = sel; wr_addr = IW'(addr); wr_data = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic load(input logic sel, input string s);
    for (int i = 0; i < s.len(); i++) wr(sel, i, s[i]);
  endtask

  task automatic start(input int tl, input int pl);
    text_len = IW'(tl); pat_len = PW'(pl);
    pulse(S_SET);
  endtask

  // Naive search: restart the pattern on mismatch, first-char hits use patron_texto_suma.
  task automatic run_search(output bit done);
    bit at_start = 1;
    logic [6:0] s;
    done = 0;
    for (int c = 0; c < 300; c++) begin
      if (fin) begin done = 1; break; end
      if (igual && at_start) begin s = S_PTS; at_start = (pat_len == PW'(1)); end
      else if (igual && pFin) begin s = S_PFIN; at_start = 1; end
      else if (igual) begin s = S_PSI; at_start = 0; end
      else if (!at_start) begin s = S_PCER; at_start = 1; end
      else begin s = S_TSUM; at_start = 1; end
      pulse(s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL reset_fin got %b exp 1", fin); end
    tests++; if (igual !== 1'b0) begin fails++; $display("FAIL reset_igual got %b exp 0", igual); end
    tests++; if (pFin !== 1'b0) begin fails++; $display("FAIL reset_pfin got %b exp 0", pFin); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (match_count !== '0) begin fails++; $display("FAIL reset_count got %0d exp 0", match_count); end
    tests++; if (match_pos !== '0) begin fails++; $display("FAIL reset_pos got %0d exp 0", match_pos); end
  endtask

  task automatic test_zero_len;
    start(6, 0);
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL zl_pat_fin got %b exp 1", fin); end
    tests++; if (igual !== 1'b0) begin fails++; $display("FAIL zl_pat_igual got %b exp 0", igual); end
    tests++; if (pFin !== 1'b0) begin fails++; $display("FAIL zl_pat_pfin got %b exp 0", pFin); end
    tests++; if (match_count !== '0) begin fails++; $display("FAIL zl_pat_count got %0d exp 0", match_count); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zl_pat_busy got %b exp 0", busy); end
    start(0, 3);
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL zl_text_fin got %b exp 1", fin); end
    tests++; if (igual !== 1'b0) begin fails++; $display("FAIL zl_text_igual got %b exp 0", igual); end
    @(posedge clk); #1;
  endtask

  task automatic test_abc;
    bit done;
    load(0, "ABCABC");
    load(1, "ABC");
    start(6, 3);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abc_busy_set got %b exp 1", busy); end
    tests++; if (igual !== 1'b1) begin fails++; $display("FAIL abc_igual0 got %b exp 1", igual); end
    run_search(done);
    tests++; if (!done) begin fails++; $display("FAIL abc_timeout got 0 exp 1"); end
    tests++; if (match_count !== 7'd2) begin fails++; $display("FAIL abc_count got %0d exp 2", match_count); end
    tests++; if (match_pos !== (POS_EN ? 7'd3 : 7'd0)) begin fails++; $display("FAIL abc_pos got %0d exp %0d", match_pos, POS_EN ? 3 : 0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abc_busy_clr got %b exp 0", busy); end
  endtask

  task automatic test_busy_write;
    start(6, 3);
    wr(0, 0, "Z");
    tests++; if (igual !== 1'b1) begin fails++; $display("FAIL bw_dropped got igual %b exp 1", igual); end
    for (int i = 0; i < 6; i++) pulse(S_TSUM);
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL bw_fin got %b exp 1", fin); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bw_busy got %b exp 0", busy); end
    wr(0, 0, "Z");
    wr(0, 64, "A");
    wr(1, 16, "Z");
    start(6, 3);
    tests++; if (igual !== 1'b0) begin fails++; $display("FAIL bw_landed got igual %b exp 0", igual); end
    for (int i = 0; i < 6; i++) pulse(S_TSUM);
    @(posedge clk); #1;
    wr(0, 0, "A");
  endtask

  task automatic test_priority;
    start(6, 3);
    pulse(S_PTS);
    pulse(S_PSI);
    tests++; if (pFin !== 1'b1) begin fails++; $display("FAIL pri_pfin_pre got %b exp 1", pFin); end
    tests++; if (igual !== 1'b1) begin fails++; $display("FAIL pri_igual_pre got %b exp 1", igual); end
    pulse(S_PFIN | S_TSUM);
    tests++; if (match_count !== 7'd1) begin fails++; $display("FAIL pri_count got %0d exp 1", match_count); end
    tests++; if (pFin !== 1'b0) begin fails++; $display("FAIL pri_pfin_post got %b exp 0", pFin); end
    tests++; if (igual !== 1'b1) begin fails++; $display("FAIL pri_igual_post got %b exp 1", igual); end
    for (int i = 0; i < 5; i++) pulse(S_TSUM);
    pulse(S_PFIN);
    tests++; if (match_count !== 7'd2) begin fails++; $display("FAIL pri_count2 got %0d exp 2", match_count); end
`ifdef BUSCADOR_POS_EN
    tests++; if (match_pos !== 7'd4) begin fails++; $display("FAIL pri_ti_held got pos %0d exp 4", match_pos); end
`endif
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL pri_fin got %b exp 1", fin); end
  endtask

  task automatic test_reset_mid;
    bit done;
    start(6, 3);
    pulse(S_PTS);
    pulse(S_PSI);
    pulse(S_PFIN);
    #2 rst = 1;
    #1;
    tests++; if (match_count !== '0) begin fails++; $display("FAIL rm_count got %0d exp 0", match_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy got %b exp 0", busy); end
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL rm_fin got %b exp 1", fin); end
    tests++; if (igual !== 1'b0) begin fails++; $display("FAIL rm_igual got %b exp 0", igual); end
    tests++; if (pFin !== 1'b0) begin fails++; $display("FAIL rm_pfin got %b exp 0", pFin); end
    tests++; if (match_pos !== '0) begin fails++; $display("FAIL rm_pos got %0d exp 0", match_pos); end
    @(posedge clk); #1 rst = 0;
    start(6, 3);
    run_search(done);
    tests++; if (!done) begin fails++; $display("FAIL rm_timeout got 0 exp 1"); end
    tests++; if (match_count !== 7'd2) begin fails++; $display("FAIL rm_count2 got %0d exp 2", match_count); end
    tests++; if (match_pos !== (POS_EN ? 7'd3 : 7'd0)) begin fails++; $display("FAIL rm_pos2 got %0d exp %0d", match_pos, POS_EN ? 3 : 0); end
  endtask

  task automatic test_single_char;
    bit done;
    load(0, "AAAA");
    load(1, "A");
    start(4, 1);
    run_search(done);
    tests++; if (!done) begin fails++; $display("FAIL sc_timeout got 0 exp 1"); end
    tests++; if (match_count !== 7'd4) begin fails++; $display("FAIL sc_count got %0d exp 4", match_count); end
    tests++; if (match_pos !== (POS_EN ? 7'd3 : 7'd0)) begin fails++; $display("FAIL sc_pos got %0d exp %0d", match_pos, POS_EN ? 3 : 0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sc_busy got %b exp 0", busy); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset;
    test_zero_len;
    test_abc;
    test_busy_write;
    test_priority;
    test_reset_mid;
    test_single_char;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
